eth_backoff_ctrl: RTL and testbench
===================================

// Module: eth_backoff_ctrl
// PURPOSE
//   Half-duplex collision/retry controller for the Ethernet TX path.
//   Tracks one frame attempt: on collision it jams, then backs off a random number of slot times, then defers and requests a retry.
//   Drives StateJam/StateJam_q/RetryCnt/NibCnt/ByteCnt into eth_random.
//   Consumes RandomEq0/RandomEqByteCnt from eth_random.
//   Sits beside the TX state machine: gets frame start/end and collision, returns retry/abort/done pulses.
// PARAMETERS
//   MAX_RET         15   collision count (RetryCnt value) at which a further collision aborts the frame
//   JAM_NIBBLES     8    jam length in nibbles (32 bits)
//   IPG_NIBBLES     24   defer gap after carrier drops (96 bits)
//   LATE_COLL_NIBS  128  DATA nibble count after which a collision is late (512 bits)
// PORTS
//   MTxClk          in   1   TX nibble clock
//   Resetn          in   1   asynchronous, active-low reset
//   TxStartFrm      in   1   start new frame (honoured only in IDLE)
//   TxEndFrm        in   1   last nibble of frame sent
//   Collision       in   1   collision detect from PHY
//   CarrierSense    in   1   medium busy
//   FullDuplex      in   1   1 = Collision ignored
//   RandomEq0       in   1   from eth_random
//   RandomEqByteCnt in   1   from eth_random
//   StateJam        out  1   state==JAM
//   StateJam_q      out  1   StateJam delayed one MTxClk
//   RetryCnt        out  4   collisions on current frame
//   NibCnt          out  16  nibble counter (state-dependent)
//   ByteCnt         out  10  slot counter during BACKOFF
//   TxRetry         out  1   1-cycle pulse: restart frame
//   TxAbort         out  1   1-cycle pulse: frame dropped
//   TxDone          out  1   1-cycle pulse: frame completed
//   LateColl        out  1   1-cycle pulse with TxAbort on late collision
// BEHAVIOUR
//   Reset: state=IDLE; all outputs and counters 0.
//   States: IDLE, DATA, JAM, BACKOFF, DEFER, ABORT (registered FSM).
//   IDLE:
//     - TxStartFrm -> DATA; RetryCnt<=0; NibCnt<=0.
//   DATA:
//     - NibCnt +1 per cycle.
//     - Collision & ~FullDuplex -> JAM; RetryCnt<=RetryCnt+1, saturates at 15; NibCnt<=0.
//     - Else TxEndFrm -> IDLE with TxDone=1.
//     - Collision and TxEndFrm in the same cycle: collision wins.
//   JAM:
//     - NibCnt +1 per cycle; exit after JAM_NIBBLES cycles (NibCnt==JAM_NIBBLES-1).
//     - Exit to ABORT if the collision that entered JAM found RetryCnt==MAX_RET (flag latched on entry); else to BACKOFF.
//     - eth_random latches its value on StateJam&StateJam_q, so RandomEq0 is valid from the first BACKOFF cycle.
//   BACKOFF:
//     - Entry: NibCnt<=0, ByteCnt<=1.
//     - First cycle: RandomEq0 -> DEFER (1 cycle total).
//     - Otherwise NibCnt +1 per cycle. When NibCnt[6:0]==7'h7F: ByteCnt+1, and if RandomEqByteCnt -> DEFER.
//     - Residency for random r>0: exactly r*128 cycles.
//     - NibCnt wraps mod 2^16; ByteCnt wraps mod 2^10 (r<=1023 never wraps).
//   DEFER:
//     - NibCnt<=0 while CarrierSense; else NibCnt+1.
//     - At NibCnt==IPG_NIBBLES-1 with ~CarrierSense -> DATA, TxRetry=1, NibCnt<=0.
//   ABORT:
//     - 1 cycle: TxAbort=1, RetryCnt<=0 -> IDLE.
//   Misc:
//     - TxStartFrm outside IDLE is ignored.
//     - FullDuplex rising mid-JAM/BACKOFF does not cut the sequence short.
//     - Resetn low at any time: immediate return to reset values; no pulses generated.
// CONFIGURATION
//   ETH_BACKOFF_LATE_COLL_EN defined:
//     - A collision in DATA with NibCnt>=LATE_COLL_NIBS still jams.
//     - JAM then exits to ABORT; TxAbort and LateColl pulse together; no retry.
//   Not defined:
//     - Late collisions are handled as normal collisions (retry).
//     - LateColl is tied to 0.
// TESTING
//   1. No collision: TxStartFrm, TxEndFrm after 20 cycles -> TxDone pulse; RetryCnt=0; back in IDLE.
//   2. Collision at DATA nib 10, RandomEq0=1 -> StateJam high 8 cycles; RetryCnt=1; 1 BACKOFF cycle;
//      DEFER 24 cycles (CarrierSense=0) -> TxRetry.
//   3. Collision, eth_random latch=3 -> BACKOFF residency exactly 384 cycles; exit on ByteCnt==3 & NibCnt[6:0]==7F.
//   4. 16 consecutive collisions -> 16th jam ends in ABORT: TxAbort=1; RetryCnt reads 15 then 0; no TxRetry.
//   5. CarrierSense high 50 cycles in DEFER, then low -> TxRetry 24 cycles after drop;
//      Collision+TxEndFrm same cycle -> JAM, no TxDone.
//   6. Macro on, collision at DATA nib 200 -> 8-cycle JAM then TxAbort+LateColl; macro off -> BACKOFF/retry.

Source files
------------

// File: rtl/eth_backoff_ctrl_if.sv
// Bundles the signals that pass between the half-duplex backoff controller
// and its neighbours: the TX state machine and eth_random.
// The master side drives frame/collision/random status.
// The slave side is the controller.
interface eth_backoff_ctrl_if;
  logic        TxStartFrm;
  logic        TxEndFrm;
  logic        Collision;
  logic        CarrierSense;
  logic        FullDuplex;
  logic        RandomEq0;
  logic        RandomEqByteCnt;
  logic        StateJam;
  logic        StateJam_q;
  logic [3:0]  RetryCnt;
  logic [15:0] NibCnt;
  logic [9:0]  ByteCnt;
  logic        TxRetry;
  logic        TxAbort;
  logic        TxDone;
  logic        LateColl;

  modport master (
    output TxStartFrm, TxEndFrm, Collision, CarrierSense, FullDuplex,
           RandomEq0, RandomEqByteCnt,
    input  StateJam, StateJam_q, RetryCnt, NibCnt, ByteCnt,
           TxRetry, TxAbort, TxDone, LateColl
  );

  modport slave (
    input  TxStartFrm, TxEndFrm, Collision, CarrierSense, FullDuplex,
           RandomEq0, RandomEqByteCnt,
    output StateJam, StateJam_q, RetryCnt, NibCnt, ByteCnt,
           TxRetry, TxAbort, TxDone, LateColl
  );
endinterface

// File: rtl/eth_backoff_ctrl.sv
// Half-duplex collision/retry controller for the Ethernet TX path.
// A frame attempt that collides goes through JAM and a random BACKOFF.
// It then goes through DEFER (the inter-packet gap) before a retry is requested.
// Optional feature macro: ETH_BACKOFF_LATE_COLL_EN.
// When it is defined, a collision after LATE_COLL_NIBS data nibbles aborts the frame
// after the jam, and the abort is flagged with LateColl.
module eth_backoff_ctrl #(
  parameter int MAX_RET        = 15,
  parameter int JAM_NIBBLES    = 8,
  parameter int IPG_NIBBLES    = 24,
  parameter int LATE_COLL_NIBS = 128
) (
  input  logic               MTxClk,
  input  logic               Resetn,
  eth_backoff_ctrl_if.slave  bus
);

`ifdef ETH_BACKOFF_LATE_COLL_EN
  localparam bit LATE_EN = 1'b1;
`else
  localparam bit LATE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_JAM, S_BACKOFF, S_DEFER, S_ABORT
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  retry_cnt_q, retry_cnt_d;
  logic [15:0] nib_cnt_q, nib_cnt_d;
  logic [9:0]  byte_cnt_q, byte_cnt_d;
  logic        abort_pend_q, abort_pend_d;   // jam must end in ABORT (retry limit)
  logic        late_pend_q, late_pend_d;     // jam must end in ABORT (late collision)
  logic        state_jam_q, state_jam_d;
  logic        tx_retry_q, tx_retry_d;
  logic        tx_abort_q, tx_abort_d;
  logic        tx_done_q, tx_done_d;
  logic        late_coll_q, late_coll_d;
  logic        coll;

  assign coll = bus.Collision & ~bus.FullDuplex;

  // State and counter registers; pulses are registered so they are glitch-free.
  always_ff @(posedge MTxClk or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= S_IDLE;
      retry_cnt_q  <= '0;
      nib_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      abort_pend_q <= 1'b0;
      late_pend_q  <= 1'b0;
      state_jam_q  <= 1'b0;
      tx_retry_q   <= 1'b0;
      tx_abort_q   <= 1'b0;
      tx_done_q    <= 1'b0;
      late_coll_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      retry_cnt_q  <= retry_cnt_d;
      nib_cnt_q    <= nib_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      abort_pend_q <= abort_pend_d;
      late_pend_q  <= late_pend_d;
      state_jam_q  <= state_jam_d;
      tx_retry_q   <= tx_retry_d;
      tx_abort_q   <= tx_abort_d;
      tx_done_q    <= tx_done_d;
      late_coll_q  <= late_coll_d;
    end
  end

  // Next-state, counter updates and pulse generation.
  always_comb begin
    state_d      = state_q;
    retry_cnt_d  = retry_cnt_q;
    nib_cnt_d    = nib_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    abort_pend_d = abort_pend_q;
    late_pend_d  = late_pend_q;
    state_jam_d  = (state_q == S_JAM);
    tx_retry_d   = 1'b0;
    tx_abort_d   = 1'b0;
    tx_done_d    = 1'b0;
    late_coll_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.TxStartFrm) begin
          state_d     = S_DATA;
          retry_cnt_d = '0;
          nib_cnt_d   = '0;
        end
      end
      S_DATA: begin
        nib_cnt_d = nib_cnt_q + 16'd1;
        if (coll) begin
          // Collision beats a simultaneous TxEndFrm.
          state_d      = S_JAM;
          retry_cnt_d  = (retry_cnt_q == 4'hF) ? 4'hF : retry_cnt_q + 4'd1;
          nib_cnt_d    = '0;
          abort_pend_d = (retry_cnt_q == 4'(MAX_RET));
          late_pend_d  = LATE_EN && (nib_cnt_q >= 16'(LATE_COLL_NIBS));
        end else if (bus.TxEndFrm) begin
          state_d   = S_IDLE;
          tx_done_d = 1'b1;
        end
      end
      S_JAM: begin
        nib_cnt_d = nib_cnt_q + 16'd1;
        if (nib_cnt_q == 16'(JAM_NIBBLES - 1)) begin
          if (abort_pend_q || late_pend_q) begin
            state_d     = S_ABORT;
            tx_abort_d  = 1'b1;
            late_coll_d = late_pend_q;
          end else begin
            state_d    = S_BACKOFF;
            nib_cnt_d  = '0;
            byte_cnt_d = 10'd1;
          end
        end
      end
      S_BACKOFF: begin
        // StateJam_q is high only on the first BACKOFF cycle.
        if (state_jam_q && bus.RandomEq0) begin
          state_d   = S_DEFER;
          nib_cnt_d = '0;
        end else begin
          nib_cnt_d = nib_cnt_q + 16'd1;
          if (nib_cnt_q[6:0] == 7'h7F) begin
            byte_cnt_d = byte_cnt_q + 10'd1;
            if (bus.RandomEqByteCnt) begin
              state_d   = S_DEFER;
              nib_cnt_d = '0;
            end
          end
        end
      end
      S_DEFER: begin
        if (bus.CarrierSense) begin
          nib_cnt_d = '0;
        end else if (nib_cnt_q == 16'(IPG_NIBBLES - 1)) begin
          state_d    = S_DATA;
          nib_cnt_d  = '0;
          tx_retry_d = 1'b1;
        end else begin
          nib_cnt_d = nib_cnt_q + 16'd1;
        end
      end
      S_ABORT: begin
        state_d      = S_IDLE;
        retry_cnt_d  = '0;
        abort_pend_d = 1'b0;
        late_pend_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.StateJam   = (state_q == S_JAM);
  assign bus.StateJam_q = state_jam_q;
  assign bus.RetryCnt   = retry_cnt_q;
  assign bus.NibCnt     = nib_cnt_q;
  assign bus.ByteCnt    = byte_cnt_q;
  assign bus.TxRetry    = tx_retry_q;
  assign bus.TxAbort    = tx_abort_q;
  assign bus.TxDone     = tx_done_q;
  assign bus.LateColl   = late_coll_q;

endmodule

// File: tb/tb_eth_backoff_ctrl.sv
// Randomised bench for eth_backoff_ctrl.
// Frame attempts are scored against timing predicted from the protocol rules:
// jam length, backoff residency per random value, and the IPG after carrier drop.
// eth_random is modelled by a latched value compared with ByteCnt.
module tb_eth_backoff_ctrl;
`ifdef ETH_BACKOFF_LATE_COLL_EN
  localparam bit LATE_EN = 1'b1;
`else
  localparam bit LATE_EN = 1'b0;
`endif

  logic MTxClk = 1'b0;
  logic Resetn = 1'b0;
  always #5 MTxClk = ~MTxClk;

  eth_backoff_ctrl_if bus();
  eth_backoff_ctrl dut (.MTxClk(MTxClk), .Resetn(Resetn), .bus(bus.slave));

  int unsigned rand_val = 1;
  assign bus.RandomEq0       = (rand_val == 0);
  assign bus.RandomEqByteCnt = (rand_val == 32'(bus.ByteCnt));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge MTxClk);
    #1;
  endtask

  // One frame: n_coll collisions at data nibble coll_nib, then a clean end.
  // cs < 0 picks a random carrier-busy time per attempt; r_fix < 0 picks a random backoff value.
  task automatic run_frame(input int n_coll, input int coll_nib, input int data_len,
                           input int cs, input int r_fix, input bit both);
    int m_retry;
    int cyc;
    int bo;
    int csv;
    bit late;
    bit abort;
    m_retry = 0;
    bus.TxStartFrm = 1'b1;
    step();
    bus.TxStartFrm = 1'b0;
    chk("start_nib", bus.NibCnt, 0);
    chk("start_retry", bus.RetryCnt, 0);
    for (int a = 1; a <= n_coll + 1; a++) begin
      step();
      chk("retry_width", bus.TxRetry, 0);
      if (a == n_coll + 1) begin
        repeat (data_len - 1) step();
        chk("end_nib", bus.NibCnt, data_len);
        bus.TxEndFrm = 1'b1;
        step();
        bus.TxEndFrm = 1'b0;
        chk("done_pulse", bus.TxDone, 1);
        chk("done_retry", bus.RetryCnt, m_retry);
        step();
        chk("done_width", bus.TxDone, 0);
        return;
      end
      repeat (coll_nib - 1) step();
      chk("coll_nib", bus.NibCnt, coll_nib);
      late  = LATE_EN && (coll_nib >= 128);
      abort = (m_retry == 15) || late;
      m_retry = (m_retry == 15) ? 15 : m_retry + 1;
      rand_val = (r_fix >= 0) ? r_fix : $urandom_range(0, 3);
      bus.Collision = 1'b1;
      bus.TxEndFrm  = both;
      step();
      bus.Collision = 1'b0;
      bus.TxEndFrm  = 1'b0;
      chk("jam_enter", bus.StateJam, 1);
      chk("jam_retry", bus.RetryCnt, m_retry);
      chk("jam_no_done", bus.TxDone, 0);
      cyc = 0;
      while (bus.StateJam === 1'b1 && cyc < 20) begin
        cyc++;
        bus.FullDuplex = 1'($urandom);
        bus.TxStartFrm = 1'($urandom);
        step();
      end
      bus.FullDuplex = 1'b0;
      bus.TxStartFrm = 1'b0;
      chk("jam_len", cyc, 8);
      if (abort) begin
        chk("abort_pulse", bus.TxAbort, 1);
        chk("late_coll", bus.LateColl, late);
        chk("abort_retry", bus.RetryCnt, m_retry);
        step();
        chk("abort_width", bus.TxAbort, 0);
        chk("abort_clr", bus.RetryCnt, 0);
        chk("abort_no_retry", bus.TxRetry, 0);
        return;
      end
      chk("no_abort", bus.TxAbort, 0);
      chk("bo_byte_init", bus.ByteCnt, 1);
      bo  = (rand_val == 0) ? 1 : rand_val * 128;
      csv = (cs >= 0) ? cs : $urandom_range(0, 6);
      cyc = 0;
      while (bus.TxRetry !== 1'b1 && cyc < bo + csv + 100) begin
        bus.CarrierSense = (cyc < bo + csv);
        if (cyc < bo) begin
          bus.FullDuplex = 1'($urandom);
          bus.TxStartFrm = 1'($urandom);
        end else begin
          bus.FullDuplex = 1'b0;
          bus.TxStartFrm = 1'b0;
        end
        step();
        cyc++;
      end
      bus.CarrierSense = 1'b0;
      bus.FullDuplex   = 1'b0;
      bus.TxStartFrm   = 1'b0;
      chk("retry_latency", cyc, bo + csv + 24);
      chk("retry_nib", bus.NibCnt, 0);
      chk("bo_byte_end", bus.ByteCnt, (rand_val == 0) ? 1 : rand_val + 1);
      chk("retry_cnt_hold", bus.RetryCnt, m_retry);
    end
  endtask

  initial begin
    bus.TxStartFrm   = 1'b0;
    bus.TxEndFrm     = 1'b0;
    bus.Collision    = 1'b0;
    bus.CarrierSense = 1'b0;
    bus.FullDuplex   = 1'b0;
    repeat (3) step();
    chk("rst_jam", bus.StateJam, 0);
    chk("rst_jam_q", bus.StateJam_q, 0);
    chk("rst_retry", bus.RetryCnt, 0);
    chk("rst_nib", bus.NibCnt, 0);
    chk("rst_byte", bus.ByteCnt, 0);
    chk("rst_pulses", {bus.TxRetry, bus.TxAbort, bus.TxDone, bus.LateColl}, 0);
    @(negedge MTxClk);
    Resetn = 1'b1;
    step();

    // Directed cases.
    run_frame(0, 1, 20, 0, 0, 1'b0);      // clean frame
    run_frame(1, 10, 20, 0, 0, 1'b0);     // r=0: one backoff cycle
    run_frame(1, 10, 20, 0, 3, 1'b0);     // r=3: 384 backoff cycles
    run_frame(16, 5, 20, -1, -1, 1'b0);   // retry limit -> abort
    run_frame(1, 7, 20, 50, 1, 1'b0);     // carrier busy 50 cycles in DEFER
    run_frame(1, 12, 20, 0, -1, 1'b1);    // Collision + TxEndFrm together
    run_frame(1, 200, 210, 0, -1, 1'b0);  // late collision

    // Collision while full duplex is ignored.
    bus.TxStartFrm = 1'b1;
    step();
    bus.TxStartFrm = 1'b0;
    repeat (5) step();
    bus.FullDuplex = 1'b1;
    bus.Collision  = 1'b1;
    step();
    bus.FullDuplex = 1'b0;
    bus.Collision  = 1'b0;
    chk("fd_no_jam", bus.StateJam, 0);
    chk("fd_nib", bus.NibCnt, 6);
    bus.TxEndFrm = 1'b1;
    step();
    bus.TxEndFrm = 1'b0;
    chk("fd_done", bus.TxDone, 1);
    step();

    // Randomised frames.
    for (int i = 0; i < 8; i++)
      run_frame($urandom_range(0, 3), $urandom_range(1, 40), $urandom_range(1, 40),
                -1, -1, 1'($urandom));

    // Asynchronous reset in the middle of backoff.
    rand_val = 2;
    bus.TxStartFrm = 1'b1;
    step();
    bus.TxStartFrm = 1'b0;
    repeat (4) step();
    bus.Collision = 1'b1;
    step();
    bus.Collision = 1'b0;
    repeat (30) step();
    #2 Resetn = 1'b0;
    #1;
    chk("arst_retry", bus.RetryCnt, 0);
    chk("arst_nib", bus.NibCnt, 0);
    chk("arst_byte", bus.ByteCnt, 0);
    chk("arst_jam", {bus.StateJam, bus.StateJam_q}, 0);
    repeat (3) step();
    chk("arst_pulses", {bus.TxRetry, bus.TxAbort, bus.TxDone, bus.LateColl}, 0);
    @(negedge MTxClk);
    Resetn = 1'b1;
    step();
    run_frame(1, 3, 8, -1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
